// File: rtl/xpt_sequencer.sv
// rtl/xpt_sequencer.sv - instruction phase sequencer: opcode fetch, phase counting, operand capture
module xpt_sequencer (
    input  logic       CLK,
    input  logic       notRESET,
    input  logic       MEM_Ready,
    input  logic [7:0] DataIn,
    input  logic       Wait_Req,
    input  logic       OP_Load,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Set_CM1,
    input  logic       P2_Reset_ITABLE,
    output logic       CM1,
    output logic       DecodeEnable,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic       OP7,
    output logic       notOP7,
    output logic [7:0] OP,
    output logic       Fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] xpt_q, xpt_d;
    logic [7:0] itable_q, itable_d;
    logic [7:0] op_q, op_d;

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state_q  <= ST_FETCH;
            xpt_q    <= 4'h0;
            itable_q <= 8'h00;
            op_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            xpt_q    <= xpt_d;
            itable_q <= itable_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        xpt_d    = xpt_q;
        itable_d = itable_q;
        op_d     = op_q;
        case (state_q)
            ST_FETCH: begin
                if (MEM_Ready) begin
                    itable_d = DataIn;
                    xpt_d    = 4'h0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (PR_Reset_XPT) begin
                    xpt_d = 4'h0;
                    if (P2_Set_CM1) begin
                        state_d = ST_FETCH;
                    end
                end else if (!Wait_Req) begin
                    // Phase 15 has no successor: trap instead of wrapping to 0.
                    if (xpt_q == 4'hF) begin
                        state_d = ST_FAULT;
                    end else begin
                        xpt_d = xpt_q + 4'd1;
                    end
                end
                if (P2_Reset_ITABLE) begin
                    itable_d = 8'h00;
                end
                if (OP_Load && MEM_Ready) begin
                    op_d = DataIn;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    assign CM1          = (state_q == ST_FETCH);
    assign DecodeEnable = (state_q == ST_EXEC);
    assign Fault        = (state_q == ST_FAULT);
    assign XPT          = xpt_q;
    assign notXPT       = ~xpt_q;
    assign ITABLE       = itable_q;
    assign notITABLE    = ~itable_q;
    assign OP           = op_q;
    assign OP7          = op_q[7];
    assign notOP7       = ~op_q[7];

endmodule

// File: tb/tb_xpt_sequencer.sv
// tb/tb_xpt_sequencer.sv - directed and randomized checks of xpt_sequencer against a behavioural model
module tb_xpt_sequencer;

    logic       CLK;
    logic       notRESET;
    logic       MEM_Ready;
    logic [7:0] DataIn;
    logic       Wait_Req;
    logic       OP_Load;
    logic       PR_Reset_XPT;
    logic       P2_Set_CM1;
    logic       P2_Reset_ITABLE;
    logic       CM1;
    logic       DecodeEnable;
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic [7:0] ITABLE;
    logic [7:0] notITABLE;
    logic       OP7;
    logic       notOP7;
    logic [7:0] OP;
    logic       Fault;

    xpt_sequencer dut (
        .CLK            (CLK),
        .notRESET       (notRESET),
        .MEM_Ready      (MEM_Ready),
        .DataIn         (DataIn),
        .Wait_Req       (Wait_Req),
        .OP_Load        (OP_Load),
        .PR_Reset_XPT   (PR_Reset_XPT),
        .P2_Set_CM1     (P2_Set_CM1),
        .P2_Reset_ITABLE(P2_Reset_ITABLE),
        .CM1            (CM1),
        .DecodeEnable   (DecodeEnable),
        .XPT            (XPT),
        .notXPT         (notXPT),
        .ITABLE         (ITABLE),
        .notITABLE      (notITABLE),
        .OP7            (OP7),
        .notOP7         (notOP7),
        .OP             (OP),
        .Fault          (Fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: mode is "fetch", "exec" or "fault"; phase is an unbounded integer.
    string      m_mode;
    int         m_phase;
    logic [7:0] m_opcode;
    logic [7:0] m_operand;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    endtask

    task automatic model_reset();
        m_mode    = "fetch";
        m_phase   = 0;
        m_opcode  = 8'h00;
        m_operand = 8'h00;
    endtask

    task automatic model_edge();
        if (m_mode == "fetch") begin
            if (MEM_Ready) begin
                m_opcode = DataIn;
                m_phase  = 0;
                m_mode   = "exec";
            end
        end else if (m_mode == "exec") begin
            if (OP_Load && MEM_Ready) m_operand = DataIn;
            if (P2_Reset_ITABLE) m_opcode = 8'h00;
            if (PR_Reset_XPT) begin
                m_phase = 0;
                if (P2_Set_CM1) m_mode = "fetch";
            end else if (!Wait_Req) begin
                if (m_phase + 1 > 15) m_mode = "fault";
                else m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ph;
        ph = 4'(m_phase);
        chk({tag, ".CM1"},          {7'd0, CM1},          {7'd0, m_mode == "fetch"});
        chk({tag, ".DecodeEnable"}, {7'd0, DecodeEnable}, {7'd0, m_mode == "exec"});
        chk({tag, ".Fault"},        {7'd0, Fault},        {7'd0, m_mode == "fault"});
        chk({tag, ".XPT"},          {4'd0, XPT},          {4'd0, ph});
        chk({tag, ".notXPT"},       {4'd0, notXPT},       {4'd0, 4'hF - ph});
        chk({tag, ".ITABLE"},       ITABLE,               m_opcode);
        chk({tag, ".notITABLE"},    notITABLE,            8'hFF - m_opcode);
        chk({tag, ".OP"},           OP,                   m_operand);
        chk({tag, ".OP7"},          {7'd0, OP7},          {7'd0, m_operand >= 8'h80});
        chk({tag, ".notOP7"},       {7'd0, notOP7},       {7'd0, m_operand < 8'h80});
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        MEM_Ready       = 1'b0;
        DataIn          = 8'h00;
        Wait_Req        = 1'b0;
        OP_Load         = 1'b0;
        PR_Reset_XPT    = 1'b0;
        P2_Set_CM1      = 1'b0;
        P2_Reset_ITABLE = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".CM1"},          {7'd0, CM1},          8'h01);
        chk({tag, ".DecodeEnable"}, {7'd0, DecodeEnable}, 8'h00);
        chk({tag, ".XPT"},          {4'd0, XPT},          8'h00);
        chk({tag, ".notXPT"},       {4'd0, notXPT},       8'h0F);
        chk({tag, ".ITABLE"},       ITABLE,               8'h00);
        chk({tag, ".notITABLE"},    notITABLE,            8'hFF);
        chk({tag, ".OP"},           OP,                   8'h00);
        chk({tag, ".OP7"},          {7'd0, OP7},          8'h00);
        chk({tag, ".notOP7"},       {7'd0, notOP7},       8'h01);
        chk({tag, ".Fault"},        {7'd0, Fault},        8'h00);
    endtask

    // Called 1 time unit after an edge; the pulse sits entirely between edges.
    task automatic reset_pulse(input string tag);
        #3 notRESET = 1'b0;
        model_reset();
        #1 check_reset_values(tag);
        #2 notRESET = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        notRESET = 1'b1;
        #1 notRESET = 1'b0;
        #1 check_reset_values("por");
        #1 notRESET = 1'b1;

        // Decoder inputs active but no handshake: must stay in fetch.
        Wait_Req = 1'b1; PR_Reset_XPT = 1'b1; P2_Set_CM1 = 1'b1; OP_Load = 1'b1; DataIn = 8'hA5;
        step("no_ready0");
        step("no_ready1");
        idle_inputs();

        MEM_Ready = 1'b1; DataIn = 8'h18;
        step("fetch");
        chk("fetch.ITABLE_const", ITABLE, 8'h18);
        chk("fetch.notITABLE_const", notITABLE, 8'hE7);
        chk("fetch.CM1_const", {7'd0, CM1}, 8'h00);
        chk("fetch.DE_const", {7'd0, DecodeEnable}, 8'h01);
        chk("fetch.XPT_const", {4'd0, XPT}, 8'h00);

        begin
            int seq [6] = '{1, 2, 3, 3, 3, 4};
            for (int i = 0; i < 6; i++) begin
                idle_inputs();
                Wait_Req = (i == 3 || i == 4);
                if (i == 3) begin
                    OP_Load = 1'b1; MEM_Ready = 1'b1; DataIn = 8'hFE;
                end
                step("count");
                chk($sformatf("count.XPT[%0d]", i), {4'd0, XPT}, 8'(seq[i]));
            end
        end
        idle_inputs();
        chk("opload.OP", OP, 8'hFE);
        chk("opload.OP7", {7'd0, OP7}, 8'h01);
        chk("opload.notOP7", {7'd0, notOP7}, 8'h00);
        for (int i = 0; i < 4; i++) step("to8");
        chk("to8.XPT", {4'd0, XPT}, 8'h08);
        PR_Reset_XPT = 1'b1; P2_Set_CM1 = 1'b1;
        step("end_instr");
        chk("end_instr.CM1", {7'd0, CM1}, 8'h01);
        chk("end_instr.XPT", {4'd0, XPT}, 8'h00);

        idle_inputs();
        MEM_Ready = 1'b1; DataIn = 8'($urandom);
        step("fetch2");
        idle_inputs();
        for (int i = 0; i < 5; i++) step("to5");
        PR_Reset_XPT = 1'b1;
        step("reset_only");
        chk("reset_only.XPT", {4'd0, XPT}, 8'h00);
        chk("reset_only.CM1", {7'd0, CM1}, 8'h00);
        chk("reset_only.DE", {7'd0, DecodeEnable}, 8'h01);

        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            step("overflow");
            if (i == 14) chk("overflow.XPT15", {4'd0, XPT}, 8'h0F);
        end
        chk("overflow.Fault", {7'd0, Fault}, 8'h01);
        chk("overflow.DE", {7'd0, DecodeEnable}, 8'h00);
        chk("overflow.XPT_held", {4'd0, XPT}, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            MEM_Ready = 1'b1; DataIn = 8'($urandom); OP_Load = 1'b1;
            PR_Reset_XPT = 1'($urandom); P2_Set_CM1 = 1'b1; P2_Reset_ITABLE = 1'($urandom);
            step("fault_hold");
            chk("fault_hold.Fault", {7'd0, Fault}, 8'h01);
        end
        reset_pulse("fault_rst");
        idle_inputs();

        MEM_Ready = 1'b1; DataIn = 8'h5A;
        step("fetch3");
        idle_inputs();
        for (int i = 0; i < 6; i++) step("to6");
        chk("to6.XPT", {4'd0, XPT}, 8'h06);
        P2_Reset_ITABLE = 1'b1;
        reset_pulse("async_rst");
        idle_inputs();
        step("after_async");

        for (int n = 0; n < 400; n++) begin
            MEM_Ready       = 1'($urandom);
            DataIn          = 8'($urandom);
            Wait_Req        = ($urandom_range(0, 3) == 0);
            OP_Load         = 1'($urandom);
            PR_Reset_XPT    = ($urandom_range(0, 15) == 0);
            P2_Set_CM1      = 1'($urandom);
            P2_Reset_ITABLE = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) reset_pulse("rand_rst");
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
